// File: rtl/memcpy_job_scheduler_pkg.sv
// memcpy_job_scheduler_pkg: shared state encoding and constants for the
// memcpy job scheduler and its round-robin arbiter.
package memcpy_job_scheduler_pkg;

  // Scheduler FSM states; encoding is fixed so software/debug can decode it.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } sched_state_e;

  // Default watchdog limit in WAIT cycles and the watchdog counter width.
  localparam int DEFAULT_TIMEOUT_CYCLES = 65536;
  localparam int TMO_CNT_W              = 32;

endpackage

// File: rtl/memcpy_job_scheduler_rr_arbiter.sv
// memcpy_job_scheduler_rr_arbiter: combinational round-robin arbiter.
// Picks the first asserted request at or above ptr_i, wrapping at N_REQ.
module memcpy_job_scheduler_rr_arbiter
  import memcpy_job_scheduler_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int IDX_W = 2
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N_REQ-1:0] gnt_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             any_o
);

  int               cand;
  logic [IDX_W-1:0] cand_idx;
  logic             found;

  // Rotating priority search starting at the pointer.
  always_comb begin
    gnt_o    = '0;
    idx_o    = '0;
    found    = 1'b0;
    cand     = 0;
    cand_idx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      cand     = (int'(ptr_i) + i) % N_REQ;
      cand_idx = IDX_W'(cand);
      if (!found && req_i[cand_idx]) begin
        found           = 1'b1;
        gnt_o[cand_idx] = 1'b1;
        idx_o           = cand_idx;
      end
    end
  end

  assign any_o = |req_i;

endmodule

// File: rtl/memcpy_job_scheduler.sv
// memcpy_job_scheduler: shares one memcpy_engine between N_REQ requester
// channels. Arbitrates round-robin, latches the winning job, pulses
// memcpy_start, waits for a done rising edge and returns a per-channel done.
// Optional: define MEMCPY_SCHED_TIMEOUT_EN to add a WAIT watchdog that aborts
// the job after TIMEOUT_CYCLES and flags it on req_err.
module memcpy_job_scheduler
  import memcpy_job_scheduler_pkg::*;
#(
  parameter int ADDR_WIDTH     = 64,
  parameter int N_REQ          = 4,
  parameter int IDX_W          = 2,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [N_REQ-1:0]            req_valid,
  input  logic [N_REQ*ADDR_WIDTH-1:0] req_src_addr,
  input  logic [N_REQ*ADDR_WIDTH-1:0] req_tgt_addr,
  input  logic [N_REQ*64-1:0]         req_len,
  output logic [N_REQ-1:0]            req_ready,
  output logic [N_REQ-1:0]            req_done,
  output logic                        req_err,
  output logic [ADDR_WIDTH-1:0]       memcpy_src_addr,
  output logic [ADDR_WIDTH-1:0]       memcpy_tgt_addr,
  output logic [63:0]                 memcpy_len,
  output logic                        memcpy_start,
  input  logic                        memcpy_done,
  output logic                        sched_busy,
  output logic [IDX_W-1:0]            cur_grant
);

  sched_state_e          state_q, state_d;
  logic [IDX_W-1:0]      ptr_q, ptr_d, grant_q, grant_d;
  logic [ADDR_WIDTH-1:0] src_q, src_d, tgt_q, tgt_d, src_sel, tgt_sel;
  logic [63:0]           len_q, len_d, len_sel;
  logic [N_REQ-1:0]      ready_q, ready_d, rdone_q, rdone_d, grant_oh;
  logic                  start_q, start_d, err_q, err_d, busy_q, busy_d;
  logic                  done_q, done_rise, timeout_hit;
  logic [N_REQ-1:0]      arb_gnt;
  logic [IDX_W-1:0]      arb_idx;
  logic                  arb_any;

  memcpy_job_scheduler_rr_arbiter #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_arb (
    .req_i (req_valid),
    .ptr_i (ptr_q),
    .gnt_o (arb_gnt),
    .idx_o (arb_idx),
    .any_o (arb_any)
  );

  // A level already high when WAIT is entered must not count as completion.
  assign done_rise = memcpy_done & ~done_q;

`ifdef MEMCPY_SCHED_TIMEOUT_EN
  logic [TMO_CNT_W-1:0] tmo_cnt_q;

  // Watchdog: zero outside WAIT, counts every WAIT cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 tmo_cnt_q <= '0;
    else if (state_q != ST_WAIT) tmo_cnt_q <= '0;
    else                        tmo_cnt_q <= tmo_cnt_q + 1'b1;
  end

  assign timeout_hit = (tmo_cnt_q == TMO_CNT_W'(TIMEOUT_CYCLES - 1));
`else
  logic [31:0] unused_tmo;
  assign unused_tmo  = TIMEOUT_CYCLES;
  assign timeout_hit = 1'b0;
`endif

  // Mux the winning channel's job and decode the in-service grant to one-hot.
  always_comb begin
    src_sel  = '0;
    tgt_sel  = '0;
    len_sel  = '0;
    grant_oh = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (arb_gnt[k]) begin
        src_sel = req_src_addr[k*ADDR_WIDTH +: ADDR_WIDTH];
        tgt_sel = req_tgt_addr[k*ADDR_WIDTH +: ADDR_WIDTH];
        len_sel = req_len[k*64 +: 64];
      end
      grant_oh[k] = (grant_q == IDX_W'(k));
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (arb_any) state_d = ST_START;
      ST_START: state_d = (len_q != '0) ? ST_WAIT : ST_DONE;
      ST_WAIT:  if (done_rise || timeout_hit) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Next values of the registered outputs, computed from the transition so
  // every output is a flop.
  always_comb begin
    src_d   = src_q;
    tgt_d   = tgt_q;
    len_d   = len_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    ready_d = '0;
    start_d = 1'b0;
    rdone_d = '0;
    err_d   = 1'b0;
    busy_d  = (state_d != ST_IDLE);
    if (state_q == ST_IDLE && arb_any) begin
      src_d   = src_sel;
      tgt_d   = tgt_sel;
      len_d   = len_sel;
      grant_d = arb_idx;
      ready_d = arb_gnt;
      start_d = (len_sel != '0);
    end
    if (state_d == ST_DONE && state_q != ST_DONE) begin
      rdone_d = grant_oh;
      err_d   = (state_q == ST_WAIT) && timeout_hit && !done_rise;
    end
    if (state_q == ST_DONE) begin
      ptr_d = (grant_q == IDX_W'(N_REQ - 1)) ? '0 : grant_q + 1'b1;
    end
  end

  // Output, job and pointer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      src_q   <= '0;
      tgt_q   <= '0;
      len_q   <= '0;
      grant_q <= '0;
      ptr_q   <= '0;
      ready_q <= '0;
      rdone_q <= '0;
      start_q <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      src_q   <= src_d;
      tgt_q   <= tgt_d;
      len_q   <= len_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      ready_q <= ready_d;
      rdone_q <= rdone_d;
      start_q <= start_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      done_q  <= memcpy_done;
    end
  end

  assign memcpy_src_addr = src_q;
  assign memcpy_tgt_addr = tgt_q;
  assign memcpy_len      = len_q;
  assign memcpy_start    = start_q;
  assign req_ready       = ready_q;
  assign req_done        = rdone_q;
  assign req_err         = err_q;
  assign sched_busy      = busy_q;
  assign cur_grant       = grant_q;

endmodule

// File: tb/tb_memcpy_job_scheduler.sv
// tb_memcpy_job_scheduler: randomized requesters and engine around the
// scheduler, a transaction-timeline reference model checked every cycle,
// and directed scenarios with hand-computed expectations.
module tb_memcpy_job_scheduler;

  localparam int N   = 4;
  localparam int AW  = 64;
  localparam int IW  = 2;
  localparam int TMO = 100;
`ifdef MEMCPY_SCHED_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    req_valid = '0;
  logic [N*AW-1:0] req_src_addr = '0;
  logic [N*AW-1:0] req_tgt_addr = '0;
  logic [N*64-1:0] req_len = '0;
  logic [N-1:0]    req_ready, req_done;
  logic            req_err;
  logic [AW-1:0]   memcpy_src_addr, memcpy_tgt_addr;
  logic [63:0]     memcpy_len;
  logic            memcpy_start;
  logic            memcpy_done = 1'b0;
  logic            sched_busy;
  logic [IW-1:0]   cur_grant;

  memcpy_job_scheduler #(
    .ADDR_WIDTH     (AW),
    .N_REQ          (N),
    .IDX_W          (IW),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .req_valid       (req_valid),
    .req_src_addr    (req_src_addr),
    .req_tgt_addr    (req_tgt_addr),
    .req_len         (req_len),
    .req_ready       (req_ready),
    .req_done        (req_done),
    .req_err         (req_err),
    .memcpy_src_addr (memcpy_src_addr),
    .memcpy_tgt_addr (memcpy_tgt_addr),
    .memcpy_len      (memcpy_len),
    .memcpy_start    (memcpy_start),
    .memcpy_done     (memcpy_done),
    .sched_busy      (sched_busy),
    .cur_grant       (cur_grant)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s cycle=%0d got=0x%0h expected=0x%0h", name, cyc, act, exp);
    end
  endtask

  // ---------------- reference model (job timeline) ----------------
  bit          m_act = 1'b0, m_zero = 1'b0, m_err = 1'b0, m_prev_done = 1'b0;
  bit          idle_now, found;
  int          m_g = 0, m_s = 0, m_d = -1, m_ptr = 0, c = 0;
  logic [63:0] e_src = '0, e_tgt = '0, e_len = '0, p_src, p_tgt, p_len;
  int          e_grant = 0;
  logic [N-1:0] x_ready, x_done;
  bit          x_start, x_err, x_busy;

  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      chk("reset_ready_done", 64'({req_ready, req_done}), 64'd0);
      chk("reset_addr_len", memcpy_src_addr | memcpy_tgt_addr | memcpy_len, 64'd0);
      chk("reset_ctl", 64'({req_err, memcpy_start, sched_busy, cur_grant}), 64'd0);
      m_act = 1'b0; m_ptr = 0; m_prev_done = 1'b0; m_d = -1;
      e_src = '0; e_tgt = '0; e_len = '0; e_grant = 0;
    end else begin
      if (m_act && cyc == m_s) begin
        e_src = p_src; e_tgt = p_tgt; e_len = p_len; e_grant = m_g;
      end
      x_ready = '0; x_done = '0;
      if (m_act && cyc == m_s) x_ready[m_g] = 1'b1;
      if (m_act && cyc == m_d) x_done[m_g] = 1'b1;
      x_start = m_act && cyc == m_s && !m_zero;
      x_err   = m_act && cyc == m_d && m_err;
      x_busy  = m_act && cyc >= m_s && (m_d < 0 || cyc <= m_d);
      chk("req_ready", 64'(req_ready), 64'(x_ready));
      chk("req_done", 64'(req_done), 64'(x_done));
      chk("req_err", 64'(req_err), 64'(x_err));
      chk("memcpy_start", 64'(memcpy_start), 64'(x_start));
      chk("sched_busy", 64'(sched_busy), 64'(x_busy));
      chk("cur_grant", 64'(cur_grant), 64'(e_grant));
      chk("memcpy_src_addr", memcpy_src_addr, e_src);
      chk("memcpy_tgt_addr", memcpy_tgt_addr, e_tgt);
      chk("memcpy_len", memcpy_len, e_len);
      idle_now = !m_act;
      if (m_act && m_d < 0 && cyc > m_s) begin
        if (memcpy_done && !m_prev_done) m_d = cyc + 1;
        else if (TMO_EN && (cyc - (m_s + 1)) == TMO - 1) begin
          m_d = cyc + 1; m_err = 1'b1;
        end
      end
      if (m_act && m_d >= 0 && cyc >= m_d) begin
        m_act = 1'b0; m_ptr = (m_g + 1) % N;
      end
      if (idle_now && req_valid != '0) begin
        found = 1'b0;
        for (int i = 0; i < N; i++) begin
          c = (m_ptr + i) % N;
          if (!found && req_valid[c]) begin found = 1'b1; m_g = c; end
        end
        p_src  = req_src_addr[m_g*AW +: AW];
        p_tgt  = req_tgt_addr[m_g*AW +: AW];
        p_len  = req_len[m_g*64 +: 64];
        m_act  = 1'b1; m_s = cyc + 1; m_err = 1'b0;
        m_zero = (p_len == 64'd0);
        m_d    = m_zero ? cyc + 2 : -1;
      end
      m_prev_done = memcpy_done;
    end
  end

  // ---------------- stimulus agents ----------------
  bit req_auto = 1'b0, eng_auto = 1'b0;
  int req_dly_max = 0;
  int raise_at[N];
  bit waiting[N];
  int eng_lat_min = 1, eng_lat_max = 40, eng_hold_min = 1, eng_hold_max = 60;
  int eng_rise_at = -1, eng_fall_at = -1;

  task automatic new_job(input int k, input logic [63:0] s, input logic [63:0] t, input logic [63:0] l);
    req_src_addr[k*AW +: AW] = s;
    req_tgt_addr[k*AW +: AW] = t;
    req_len[k*64 +: 64]      = l;
    req_valid[k]             = 1'b1;
  endtask

  task automatic rand_job(input int k);
    new_job(k, {$urandom, $urandom}, {$urandom, $urandom},
            ($urandom_range(4, 0) == 0) ? 64'd0 : {32'd0, $urandom});
  endtask

  // One clock: advance, then requesters and engine react to this cycle's outputs.
  task automatic step();
    @(posedge clk);
    #1;
    for (int k = 0; k < N; k++) begin
      if (req_ready[k]) begin req_valid[k] = 1'b0; waiting[k] = 1'b1; end
      if (req_done[k]) begin
        waiting[k] = 1'b0;
        if (req_auto) raise_at[k] = cyc + $urandom_range(req_dly_max, 0);
      end
      if (req_auto && !req_valid[k] && !waiting[k] && raise_at[k] >= 0 && cyc >= raise_at[k]) begin
        rand_job(k);
        raise_at[k] = -1;
      end
    end
    if (eng_auto && memcpy_start) eng_rise_at = cyc + $urandom_range(eng_lat_max, eng_lat_min);
    if (eng_rise_at >= 0 && cyc >= eng_rise_at) begin
      if (memcpy_done) begin
        memcpy_done = 1'b0; eng_rise_at = cyc + 1; eng_fall_at = -1;
      end else begin
        memcpy_done = 1'b1; eng_rise_at = -1;
        eng_fall_at = cyc + $urandom_range(eng_hold_max, eng_hold_min);
      end
    end else if (eng_fall_at >= 0 && cyc >= eng_fall_at) begin
      memcpy_done = 1'b0; eng_fall_at = -1;
    end
  endtask

  task automatic wait_idle(input int budget);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      step();
      ok = (req_valid == '0) && !sched_busy && !memcpy_done;
    end
    chk("wait_idle_reached", 64'(ok), 64'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  int got[5];
  int exp_order[5] = '{0, 1, 2, 3, 0};
  int ngot, c0, s0, r0;
  bit hit;

  initial begin
    for (int k = 0; k < N; k++) begin raise_at[k] = -1; waiting[k] = 1'b0; end
    repeat (3) step();
    rst_n = 1'b1;
    step();

    // Contention: all four channels, immediate re-raise after done.
    req_auto = 1'b1; req_dly_max = 0;
    eng_auto = 1'b1; eng_lat_min = 3; eng_lat_max = 10; eng_hold_min = 1; eng_hold_max = 2;
    for (int k = 0; k < N; k++) rand_job(k);
    ngot = 0;
    for (int i = 0; i < 600 && ngot < 5; i++) begin
      step();
      if (req_ready != '0) begin
        chk("contention_ready_onehot", 64'($countones(req_ready)), 64'd1);
        got[ngot] = int'(cur_grant);
        ngot++;
      end
    end
    chk("contention_grant_count", 64'(ngot), 64'd5);
    for (int i = 0; i < 5; i++) chk("contention_order", 64'(got[i]), 64'(exp_order[i]));
    req_auto = 1'b0;
    wait_idle(1000);

    // Single job on channel 0, engine done 40 cycles after start.
    eng_lat_min = 40; eng_lat_max = 40; eng_hold_min = 3; eng_hold_max = 3;
    new_job(0, 64'h1000, 64'h2000, 64'd256);
    c0 = cyc;
    step();
    chk("single_ready", 64'(req_ready), 64'h1);
    chk("single_start", 64'(memcpy_start), 64'd1);
    chk("single_src", memcpy_src_addr, 64'h1000);
    chk("single_tgt", memcpy_tgt_addr, 64'h2000);
    chk("single_len", memcpy_len, 64'd256);
    chk("single_start_cycle", 64'(cyc - c0), 64'd1);
    hit = 1'b0; r0 = 0;
    for (int i = 0; i < 100 && !hit; i++) begin
      step();
      if (memcpy_done) begin hit = 1'b1; r0 = cyc; end
    end
    chk("single_done_rise_cycle", 64'(r0 - c0), 64'd41);
    step();
    chk("single_req_done", 64'(req_done), 64'h1);
    chk("single_req_err", 64'(req_err), 64'd0);
    step();
    chk("single_idle_after", 64'(sched_busy), 64'd0);
    wait_idle(200);

    // Zero-length job on channel 2: engine never started.
    new_job(2, {$urandom, $urandom}, {$urandom, $urandom}, 64'd0);
    step();
    chk("zero_ready", 64'(req_ready), 64'h4);
    chk("zero_no_start_c1", 64'(memcpy_start), 64'd0);
    step();
    chk("zero_done", 64'(req_done), 64'h4);
    chk("zero_no_start_c2", 64'(memcpy_start), 64'd0);
    wait_idle(50);

    // Stale done: level high across channel 1's START is not a completion.
    eng_auto = 1'b0;
    memcpy_done = 1'b1;
    step();
    new_job(1, {$urandom, $urandom}, {$urandom, $urandom}, 64'd64);
    step();
    chk("stale_ready", 64'(req_ready), 64'h2);
    chk("stale_start", 64'(memcpy_start), 64'd1);
    for (int i = 0; i < 10; i++) begin
      step();
      chk("stale_no_done", 64'(req_done), 64'd0);
    end
    chk("stale_still_busy", 64'(sched_busy), 64'd1);
    memcpy_done = 1'b0;
    step();
    memcpy_done = 1'b1;
    step();
    chk("stale_done_after_new_edge", 64'(req_done), 64'h2);
    memcpy_done = 1'b0;
    wait_idle(50);

    // Reset during channel 3's WAIT.
    new_job(3, {$urandom, $urandom}, {$urandom, $urandom}, 64'd500);
    step();
    chk("rst_job_ready", 64'(req_ready), 64'h8);
    repeat (5) step();
    rst_n = 1'b0;
    step();
    chk("rst_busy_low", 64'(sched_busy), 64'd0);
    chk("rst_src_zero", memcpy_src_addr, 64'd0);
    step();
    step();
    rst_n = 1'b1;
    for (int k = 0; k < N; k++) begin waiting[k] = 1'b0; raise_at[k] = -1; end
    step();
    chk("rst_no_done", 64'(req_done), 64'd0);
    eng_auto = 1'b1; eng_lat_min = 1; eng_lat_max = 40; eng_hold_min = 1; eng_hold_max = 60;
    req_auto = 1'b1; req_dly_max = 20;
    for (int k = 0; k < N; k++) rand_job(k);
    step();
    chk("post_rst_grant", 64'(cur_grant), 64'd0);
    chk("post_rst_ready", 64'(req_ready), 64'h1);

    // Randomized traffic.
    repeat (4000) step();
    req_auto = 1'b0;
    wait_idle(3000);

`ifdef MEMCPY_SCHED_TIMEOUT_EN
    // Engine never answers: watchdog aborts with req_err.
    eng_auto = 1'b0;
    new_job(0, {$urandom, $urandom}, {$urandom, $urandom}, 64'd8);
    step();
    s0 = cyc;
    chk("tmo_start", 64'(memcpy_start), 64'd1);
    hit = 1'b0;
    for (int i = 0; i < 300 && !hit; i++) begin
      step();
      hit = (req_done != '0);
    end
    chk("tmo_done_cycle", 64'(cyc - (s0 + 1)), 64'(TMO));
    chk("tmo_req_done", 64'(req_done), 64'h1);
    chk("tmo_req_err", 64'(req_err), 64'd1);
    step();
    chk("tmo_idle_after", 64'(sched_busy), 64'd0);
`endif

    step();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
